// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, internal ALU operation classes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11,
    S_ORIEX   = 4'd12,
    S_XORIEX  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SRLV = 6'b000110;

  typedef enum logic [2:0] {
    AOP_ADD   = 3'd0,
    AOP_SUB   = 3'd1,
    AOP_OR    = 3'd2,
    AOP_XOR   = 3'd3,
    AOP_FUNCT = 3'd4
  } aluop_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRLV = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;

  localparam logic [2:0] SRCB_REG  = 3'b000;
  localparam logic [2:0] SRCB_FOUR = 3'b001;
  localparam logic [2:0] SRCB_SEXT = 3'b010;
  localparam logic [2:0] SRCB_SHL2 = 3'b011;
  localparam logic [2:0] SRCB_ZEXT = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: maps the controller's ALU operation class and
// the instruction funct field onto the ALU function code.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [3:0]  alucontrol
);

  always_comb begin
    // NOTE: default first so every path assigns alucontrol and no latch is inferred.
    alucontrol = ALU_ADD;
    unique case (aluop)
      AOP_ADD: alucontrol = ALU_ADD;
      AOP_SUB: alucontrol = ALU_SUB;
      AOP_OR:  alucontrol = ALU_OR;
      AOP_XOR: alucontrol = ALU_XOR;
      default: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          FN_SRLV: alucontrol = ALU_SRLV;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle MIPS datapath.
// Define MC_LBU_EN to add the lbu (load byte unsigned) instruction.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       lbu,
  output logic [3:0] state
);

  state_t state_q, state_d, out_state;
  aluop_t aluop;
  logic   pcwrite, branch, irwrite_raw, memwrite_raw, regwrite_raw;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for registered state so all flops update together.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
`ifdef MC_LBU_EN
          OP_LBU:       state_d = S_MEMADR;
`endif
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_XORI:      state_d = S_XORIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX, S_ORIEX, S_XORIEX: state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // During reset the datapath sees FETCH controls with all enables masked.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    iord         = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REG;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    pcsrc        = PCSRC_ALU;
    aluop        = AOP_ADD;
    case (out_state)
      S_FETCH: begin
        alusrcb     = SRCB_FOUR;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      S_DECODE:  alusrcb = SRCB_SHL2;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_SEXT;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = AOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        branch  = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_ZEXT;
        aluop   = AOP_OR;
      end
      S_XORIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_ZEXT;
        aluop   = AOP_XOR;
      end
      S_IMMWB:   regwrite_raw = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign irwrite  = ~reset & irwrite_raw;
  assign memwrite = ~reset & memwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign state    = state_q;

`ifdef MC_LBU_EN
  assign lbu = (out_state == S_MEMWB) && (op == OP_LBU);
`else
  assign lbu = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; expected values are
// hand-derived per instruction and state.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg, lbu;
  logic [2:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol, state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .lbu        (lbu),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;

    tick();
    check("rst1_state", state, 4'd0);
    check("rst1_pcen", pcen, 1'b0);
    check("rst1_irwrite", irwrite, 1'b0);
    tick();
    check("rst2_state", state, 4'd0);
    check("rst2_pcen", pcen, 1'b0);

    // release reset in FETCH; first post-reset cycle
    reset = 1'b0; op = 6'b100011; #1;
    check("fetch_pcen", pcen, 1'b1);
    check("fetch_irwrite", irwrite, 1'b1);
    check("fetch_alusrcb", alusrcb, 3'b001);
    check("fetch_aluctl", alucontrol, 4'b0010);

    // lw: 0,1,2,3,4,0
    tick(); check("lw_s1", state, 4'd1); check("lw_dec_srcb", alusrcb, 3'b011);
    tick(); check("lw_s2", state, 4'd2); check("lw_adr_srcb", alusrcb, 3'b010);
    check("lw_adr_srca", alusrca, 1'b1);
    tick(); check("lw_s3", state, 4'd3); check("lw_rd_iord", iord, 1'b1);
    check("lw_rd_regwrite", regwrite, 1'b0);
    tick(); check("lw_s4", state, 4'd4); check("lw_wb_regwrite", regwrite, 1'b1);
    check("lw_wb_memtoreg", memtoreg, 1'b1); check("lw_wb_lbu", lbu, 1'b0);
    tick(); check("lw_s0", state, 4'd0);

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    tick(); check("beq_s1", state, 4'd1);
    tick(); check("beq_s8", state, 4'd8); check("beq_pcen_z1", pcen, 1'b1);
    check("beq_pcsrc", pcsrc, 2'b01); check("beq_aluctl", alucontrol, 4'b1010);
    zero = 1'b0; #1;
    check("beq_pcen_z0", pcen, 1'b0);
    tick(); check("beq_s0", state, 4'd0);

    // R-type slt and srlv
    op = 6'b000000; funct = 6'b101010;
    tick(); tick(); check("slt_s6", state, 4'd6); check("slt_aluctl", alucontrol, 4'b1011);
    check("slt_srcb", alusrcb, 3'b000);
    tick(); check("slt_s7", state, 4'd7); check("slt_regdst", regdst, 1'b1);
    check("slt_regwrite", regwrite, 1'b1);
    tick(); check("slt_s0", state, 4'd0);
    funct = 6'b000110;
    tick(); tick(); check("srlv_aluctl", alucontrol, 4'b0100);
    funct = 6'b111111; #1;
    check("unk_funct_aluctl", alucontrol, 4'b0010);
    tick(); check("srlv_regdst", regdst, 1'b1);
    tick(); check("srlv_s0", state, 4'd0);

    // ori / xori
    op = 6'b001101;
    tick(); tick(); check("ori_s12", state, 4'd12); check("ori_srcb", alusrcb, 3'b100);
    check("ori_aluctl", alucontrol, 4'b0001);
    tick(); check("ori_s10", state, 4'd10); check("ori_regwrite", regwrite, 1'b1);
    check("ori_regdst", regdst, 1'b0);
    tick(); check("ori_s0", state, 4'd0);
    op = 6'b001110;
    tick(); tick(); check("xori_s13", state, 4'd13); check("xori_srcb", alusrcb, 3'b100);
    check("xori_aluctl", alucontrol, 4'b0101);
    tick(); check("xori_s10", state, 4'd10); check("xori_regwrite", regwrite, 1'b1);
    tick(); check("xori_s0", state, 4'd0);

    // addi
    op = 6'b001000;
    tick(); tick(); check("addi_s9", state, 4'd9); check("addi_srcb", alusrcb, 3'b010);
    tick(); check("addi_s10", state, 4'd10);
    tick(); check("addi_s0", state, 4'd0);

    // sw
    op = 6'b101011;
    tick(); tick(); check("sw_s2", state, 4'd2);
    tick(); check("sw_s5", state, 4'd5); check("sw_memwrite", memwrite, 1'b1);
    check("sw_iord", iord, 1'b1);
    tick(); check("sw_s0", state, 4'd0);

    // j
    op = 6'b000010;
    tick(); tick(); check("j_s11", state, 4'd11); check("j_pcen", pcen, 1'b1);
    check("j_pcsrc", pcsrc, 2'b10);
    tick(); check("j_s0", state, 4'd0);

    // opcode 100100
    op = 6'b100100;
`ifdef MC_LBU_EN
    tick(); tick(); check("lbu_s2", state, 4'd2);
    tick(); check("lbu_s3", state, 4'd3);
    tick(); check("lbu_s4", state, 4'd4); check("lbu_flag", lbu, 1'b1);
    check("lbu_regwrite", regwrite, 1'b1);
    tick(); check("lbu_s0", state, 4'd0);
`else
    tick(); check("lbu_ill_s1", state, 4'd1);
    check("lbu_ill_regwrite", regwrite, 1'b0); check("lbu_ill_memwrite", memwrite, 1'b0);
    check("lbu_ill_pcen", pcen, 1'b0);
    tick(); check("lbu_ill_s0", state, 4'd0); check("lbu_ill_flag", lbu, 1'b0);
`endif

    // other illegal opcode
    op = 6'b111111;
    tick(); tick(); check("ill_s0", state, 4'd0);

    // reset asserted mid-instruction in MEMRD
    op = 6'b100011;
    tick(); tick(); tick(); check("rstmid_s3", state, 4'd3);
    reset = 1'b1; #1;
    check("rstmid_regwrite", regwrite, 1'b0); check("rstmid_pcen", pcen, 1'b0);
    check("rstmid_iord", iord, 1'b0); check("rstmid_srcb", alusrcb, 3'b001);
    tick(); check("rstmid_s0", state, 4'd0); check("rstmid_irwrite", irwrite, 1'b0);
    reset = 1'b0; #1;
    check("rstmid_fetch_pcen", pcen, 1'b1);
    tick(); check("rstmid_s1", state, 4'd1); check("rstmid_dec_regwrite", regwrite, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
